// File: rtl/timer_pkg.sv
// Shared definitions for the cycle-time display counters: direction encoding,
// default digit moduli and the load clamp helper.
package timer_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  localparam int unsigned SEC_LSD_MOD = 10;
  localparam int unsigned SEC_MSD_MOD = 6;
  localparam int unsigned DEF_DIGIT_W = 4;

  // Out-of-range load values pin to the largest legal digit value.
  function automatic int unsigned clamp_digit(input int unsigned d, input int unsigned m);
    return (d >= m) ? (m - 1) : d;
  endfunction

endpackage

// File: rtl/mod_digit.sv
// One modulo-MOD up/down digit with parallel load and a combinational
// carry/borrow output for the next digit.
module mod_digit
  import timer_pkg::*;
#(
  parameter int unsigned       DIGIT_W = DEF_DIGIT_W,
  parameter int unsigned       MOD     = SEC_LSD_MOD,
  parameter logic [DIGIT_W-1:0] INIT_D = '0
) (
  input  logic               CLK100MHZ,
  input  logic               reset,
  input  logic               en,
  input  logic               up,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_d,
  output logic [DIGIT_W-1:0] q,
  output logic               co
);

  localparam logic [DIGIT_W-1:0] MAX = DIGIT_W'(MOD - 1);

  logic count_up;
  assign count_up = (dir_e'(up) == DIR_UP);

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      q <= INIT_D;
    end else if (load) begin
      q <= DIGIT_W'(clamp_digit(32'(load_d), MOD));
    end else if (en) begin
      if (count_up) begin
        q <= (q == MAX) ? '0 : q + 1'b1;
      end else begin
        q <= (q == '0) ? MAX : q - 1'b1;
      end
    end
  end

  // Ungated: the top also uses it to detect the terminal value.
  assign co = count_up ? (q == MAX) : (q == '0);

endmodule

// File: rtl/cascade_digit_counter.sv
// Multi-digit up/down counter stepped by rising edges of cin, with preload,
// hold, wrap/saturate at terminal, a terminal pulse and a zero flag.
module cascade_digit_counter
  import timer_pkg::*;
#(
  parameter int unsigned              DIGITS  = 2,
  parameter int unsigned              DIGIT_W = DEF_DIGIT_W,
  parameter int unsigned              LSD_MOD = SEC_LSD_MOD,
  parameter int unsigned              MSD_MOD = SEC_MSD_MOD,
  parameter logic [DIGITS*DIGIT_W-1:0] INIT   = '0
) (
  input  logic                      CLK100MHZ,
  input  logic                      reset,
  input  logic                      cin,
  input  logic                      up,
  input  logic                      wrap_en,
  input  logic                      hold,
  input  logic                      load,
  input  logic [DIGITS*DIGIT_W-1:0] load_val,
  output logic [DIGITS*DIGIT_W-1:0] count,
  output logic                      tc,
  output logic                      zero
);

  localparam int unsigned MOD0 = (DIGITS == 1) ? MSD_MOD : LSD_MOD;

  logic              old_cin;
  logic              step_evt;
  logic              step_go;
  logic              at_term;
  logic              near_term;
  logic              pre0;
  logic [DIGITS-1:0] co;
  logic [DIGITS-1:0] en;
  logic [DIGITS:0]   hi_term;

  assign step_evt = ~old_cin & cin;

  // hi_term[i]: digits i..DIGITS-1 all sit at their terminal value.
  assign hi_term[DIGITS] = 1'b1;
  assign en[0]           = step_go;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    localparam int unsigned M = (i == DIGITS - 1) ? MSD_MOD : LSD_MOD;

    mod_digit #(
      .DIGIT_W(DIGIT_W),
      .MOD    (M),
      .INIT_D (INIT[i*DIGIT_W +: DIGIT_W])
    ) u_digit (
      .CLK100MHZ(CLK100MHZ),
      .reset    (reset),
      .en       (en[i]),
      .up       (up),
      .load     (load),
      .load_d   (load_val[i*DIGIT_W +: DIGIT_W]),
      .q        (count[i*DIGIT_W +: DIGIT_W]),
      .co       (co[i])
    );

    assign hi_term[i] = hi_term[i+1] & co[i];

    if (i > 0) begin : g_chain
      assign en[i] = en[i-1] & co[i-1];
    end
  end

  assign at_term = hi_term[0];

  // One step short of terminal: digit 0 is one away, every higher digit is already there.
  assign pre0 = (dir_e'(up) == DIR_UP) ? (count[DIGIT_W-1:0] == DIGIT_W'(MOD0 - 2))
                                       : (count[DIGIT_W-1:0] == DIGIT_W'(1));
  assign near_term = pre0 & hi_term[1];

  assign step_go = step_evt & ~load & ~hold & (~at_term | wrap_en);

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      old_cin <= 1'b1;
      tc      <= 1'b0;
    end else begin
      old_cin <= cin;
      tc      <= step_go & ~at_term & near_term;
    end
  end

  assign zero = (count == '0);

endmodule
